// File: rtl/wb_rr_intercon.sv
// Shared-bus Wishbone classic interconnect: round-robin arbitration between
// masters, base/mask slave decode, unmapped-address and watchdog bus errors.
module wb_rr_intercon #(
  parameter int MASTERS_NUM    = 2,
  parameter int SLAVES_NUM     = 3,
  parameter int ADR_WIDTH      = 32,
  parameter int DAT_WIDTH      = 32,
  parameter int SEL_WIDTH      = 4,
  parameter logic [SLAVES_NUM*ADR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES_NUM*ADR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [MASTERS_NUM-1:0]           m2i_cyc_i,
  input  logic [MASTERS_NUM-1:0]           m2i_stb_i,
  input  logic [MASTERS_NUM-1:0]           m2i_we_i,
  input  logic [MASTERS_NUM*ADR_WIDTH-1:0] m2i_adr_i,
  input  logic [MASTERS_NUM*DAT_WIDTH-1:0] m2i_dat_i,
  input  logic [MASTERS_NUM*SEL_WIDTH-1:0] m2i_sel_i,
  output logic [MASTERS_NUM-1:0]           i2m_ack_o,
  output logic [MASTERS_NUM-1:0]           i2m_err_o,
  output logic [DAT_WIDTH-1:0]             i2m_dat_o,
  input  logic [SLAVES_NUM-1:0]            s2i_ack_i,
  input  logic [SLAVES_NUM-1:0]            s2i_err_i,
  input  logic [SLAVES_NUM*DAT_WIDTH-1:0]  s2i_dat_i,
  output logic [SLAVES_NUM-1:0]            i2s_stb_o,
  output logic                             i2s_cyc_o,
  output logic [ADR_WIDTH-1:0]             i2s_adr_o,
  output logic [DAT_WIDTH-1:0]             i2s_dat_o,
  output logic [SEL_WIDTH-1:0]             i2s_sel_o,
  output logic                             i2s_we_o,
  output logic [MASTERS_NUM-1:0]           gnt_o
);

  localparam int LW = (MASTERS_NUM > 1) ? $clog2(MASTERS_NUM) : 1;
  localparam int SW = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [MASTERS_NUM-1:0] gnt_q, gnt_d;
  logic [LW-1:0]          last_q, last_d;
  logic [LW-1:0]          cand;
  logic                   found;
  logic [CW-1:0]          wd_cnt_q;
  logic                   unmapped_err_q;
  logic                   timeout_err;
  logic                   err_pulse;

  logic                   busy;
  logic                   m_cyc, m_stb;
  logic [ADR_WIDTH-1:0]   m_adr;
  logic [SLAVES_NUM-1:0]  sel_hit;
  logic [SW-1:0]          sel_idx;
  logic                   hit_any;
  logic                   s_ack, s_err;
  logic                   wd_clear;

  // Arbiter; last_q doubles as the index of the current owner while BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        for (int unsigned i = 0; i < MASTERS_NUM; i++) begin
          cand = LW'((32'(last_q) + 32'd1 + i) % MASTERS_NUM);
          if (!found && m2i_cyc_i[cand]) begin
            found           = 1'b1;
            gnt_d           = '0;
            gnt_d[cand]     = 1'b1;
            last_d          = cand;
            state_d         = BUSY;
          end
        end
      end
      BUSY: begin
        if (!m2i_cyc_i[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(MASTERS_NUM - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign busy  = (state_q == BUSY);
  assign m_cyc = busy & m2i_cyc_i[last_q];
  assign m_stb = m_cyc & m2i_stb_i[last_q];
  assign m_adr = busy ? m2i_adr_i[last_q*ADR_WIDTH +: ADR_WIDTH] : '0;

  assign i2s_cyc_o = m_cyc;
  assign i2s_adr_o = m_adr;
  assign i2s_we_o  = busy & m2i_we_i[last_q];
  assign i2s_dat_o = busy ? m2i_dat_i[last_q*DAT_WIDTH +: DAT_WIDTH] : '0;
  assign i2s_sel_o = busy ? m2i_sel_i[last_q*SEL_WIDTH +: SEL_WIDTH] : '0;
  assign gnt_o     = gnt_q;

  // Address decode: lowest-index matching slave wins.
  always_comb begin
    sel_hit = '0;
    sel_idx = '0;
    hit_any = 1'b0;
    for (int unsigned s = 0; s < SLAVES_NUM; s++) begin
      if (!hit_any &&
          ((m_adr & SLAVE_MASK[s*ADR_WIDTH +: ADR_WIDTH]) == SLAVE_BASE[s*ADR_WIDTH +: ADR_WIDTH])) begin
        hit_any = 1'b1;
        sel_hit = SLAVES_NUM'(1) << s;
        sel_idx = SW'(s);
      end
    end
  end

  assign s_ack = busy & hit_any & s2i_ack_i[sel_idx];
  assign s_err = busy & hit_any & s2i_err_i[sel_idx];

  // A slave response in the firing cycle takes precedence over the timeout.
  assign timeout_err = (TIMEOUT_CYCLES != 0) && m_stb && !s_ack && !s_err &&
                       (wd_cnt_q == CW'(TIMEOUT_CYCLES));
  assign err_pulse   = unmapped_err_q | timeout_err;

  assign i2s_stb_o = sel_hit & {SLAVES_NUM{m_stb & ~err_pulse}};
  assign i2m_ack_o = gnt_q & {MASTERS_NUM{s_ack}};
  assign i2m_err_o = gnt_q & {MASTERS_NUM{s_err | err_pulse}};
  assign i2m_dat_o = (busy && hit_any) ? s2i_dat_i[sel_idx*DAT_WIDTH +: DAT_WIDTH] : '0;

  assign wd_clear = (TIMEOUT_CYCLES == 0) || !m_stb || s_ack || s_err || err_pulse;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q       <= '0;
      unmapped_err_q <= 1'b0;
    end else begin
      unmapped_err_q <= m_stb & ~hit_any & ~unmapped_err_q;
      if (wd_clear)
        wd_cnt_q <= '0;
      else
        wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/wb_rr_intercon.md
Name: wb_rr_intercon

Overview:
- Parametrised successor to the single-master shared-bus Wishbone interconnect.
- Shared-bus Wishbone classic interconnect: MASTERS_NUM masters, SLAVES_NUM slaves.
- Fair round-robin arbitration between masters; parametrised base/mask address decode.
- Generates bus errors for unmapped addresses and for slaves that stall past a watchdog limit.
- Sits between the CPU(s)/DMA masters and ROM, UART, syscon and future slaves.

Parameters:
- MASTERS_NUM, 2: number of masters (>=1).
- SLAVES_NUM, 3: number of slaves (>=1).
- ADR_WIDTH, 32: address width.
- DAT_WIDTH, 32: data width.
- SEL_WIDTH, 4: byte-select width.
- SLAVE_BASE, 0: packed SLAVES_NUM*ADR_WIDTH; slave s base at [s*ADR_WIDTH +: ADR_WIDTH].
- SLAVE_MASK, 0: packed, same layout; compare mask for slave s.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m2i_cyc_i  in  MASTERS_NUM  per-master cyc.
- m2i_stb_i  in  MASTERS_NUM  per-master stb.
- m2i_we_i  in  MASTERS_NUM  per-master we.
- m2i_adr_i  in  MASTERS_NUM*ADR_WIDTH  packed addresses, master m at [m*ADR_WIDTH +: ADR_WIDTH].
- m2i_dat_i  in  MASTERS_NUM*DAT_WIDTH  packed write data.
- m2i_sel_i  in  MASTERS_NUM*SEL_WIDTH  packed byte selects.
- i2m_ack_o  out  MASTERS_NUM  per-master ack.
- i2m_err_o  out  MASTERS_NUM  per-master err.
- i2m_dat_o  out  DAT_WIDTH  read data, shared by all masters.
- s2i_ack_i  in  SLAVES_NUM  slave acks, slave s at bit s.
- s2i_err_i  in  SLAVES_NUM  slave errs.
- s2i_dat_i  in  SLAVES_NUM*DAT_WIDTH  packed slave read data.
- i2s_stb_o  out  SLAVES_NUM  per-slave strobe.
- i2s_cyc_o  out  1  shared cyc.
- i2s_adr_o  out  ADR_WIDTH  shared address.
- i2s_dat_o  out  DAT_WIDTH  shared write data.
- i2s_sel_o  out  SEL_WIDTH  shared byte selects.
- i2s_we_o  out  1  shared write enable.
- gnt_o  out  MASTERS_NUM  one-hot current grant (debug/status).

Behaviour:
Clock/reset:
- Single clock clk_i; reset rst_i synchronous, active-high.
- Reset clears: state=IDLE, gnt_o=0, last-granted pointer=MASTERS_NUM-1, watchdog counter=0, err registers=0.
- Consequently every output is 0 after the reset edge, including mid-transfer. The aborted master receives no ack.

Arbiter FSM (states IDLE, BUSY):
- IDLE: if any m2i_cyc_i is high, grant the first requester searching from (last+1) mod MASTERS_NUM upward with wrap. Register gnt_o and last, go to BUSY. Grant is visible the cycle after the request.
- BUSY: hold the grant while the granted master's cyc is high; other masters are ignored.
- Granted cyc low in BUSY: go to IDLE, gnt_o=0 next cycle. This gives a minimum one-cycle bus gap between owners.
- A master dropping and immediately re-raising cyc loses priority to other pending requesters.

Forwarding (combinational from the granted master; all zero in IDLE):
- i2s_cyc_o/adr/dat/sel/we are muxed from the granted master.
- hit[s] = ((adr & MASK[s]) == BASE[s]). Only the lowest-index hit is selected (priority).
- i2s_stb_o[s] = stb & sel_hit[s] & ~err_pulse.
- i2m_ack_o[g] = s2i_ack_i[selected]; i2m_dat_o = s2i_dat_i[selected], 0 if no hit.
- i2m_err_o[g] = s2i_err_i[selected] | unmapped_err | timeout_err.
- Non-granted masters see ack=err=0.

Unmapped access:
- Granted stb with no hit: unmapped_err register goes high next cycle for exactly one cycle (set = stb & miss & ~unmapped_err).
- No slave strobe is asserted for an unmapped access.

Watchdog:
- Counter increments each cycle the granted stb is high with no slave ack/err.
- Counter clears on ack, err, stb low or grant change.
- When the counter reaches TIMEOUT_CYCLES, timeout_err pulses one cycle and forces all i2s_stb_o low in that cycle; the counter then clears.
- Counter width: clog2(TIMEOUT_CYCLES+1).

Simultaneous events:
- Slave ack in the same cycle the timeout fires: ack wins, no timeout_err.

Test Plan:
- Reset: rst_i=1 for 2 cycles with all cyc high -> all outputs 0, gnt_o=0; after release, gnt_o=2'b01 on the second edge.
- Round-robin: MASTERS_NUM=2, both cyc held and each releases after one ack -> grants alternate 01,00,10,00,01.
- Decode: BASE={0x1000,0x0000}, MASK={0xF000,0xF000}; read 0x1004 -> i2s_stb_o=3'b010, returned s2i_dat_i[1]=0xDEADBEEF appears on i2m_dat_o with ack.
- Unmapped: address 0x8000 -> no i2s_stb_o bit set; i2m_err_o[g]=1 for exactly one cycle, one cycle after stb.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> err pulses 4 cycles after stb rises with i2s_stb_o=0 that cycle; an ack arriving on cycle 4 -> ack only, no err.
- Reset mid-BUSY: assert rst_i during a pending write -> next cycle gnt_o=0, i2s_cyc_o=0, no ack to the master.
